// File: rtl/i4004_clock_sequencer.sv
// i4004_clock_sequencer
// Two-phase non-overlapping clock and power-on-clear generator for the 4004
// core. It tracks the 8-subcycle instruction cycle (A1..X3), checks it against
// the core's SYNC, and gives the host run/halt and single-step control.
module i4004_clock_sequencer #(
  parameter int CLK1_W  = 2,
  parameter int CLK2_W  = 2,
  parameter int GAP_W   = 1,
  parameter int POC_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       step_req,
  input  logic       poc_req,
  input  logic       sync_in,
  output logic       clk1_out,
  output logic       clk2_out,
  output logic       poc_out,
  output logic [2:0] subcycle,
  output logic       cycle_start,
  output logic       halted,
  output logic       step_ack,
  output logic       sync_err
);

  localparam int P     = CLK1_W + CLK2_W + 2 * GAP_W;
  localparam int PH_W  = $clog2(P);
  localparam int POC_W = $clog2(POC_CYC + 1);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(P - 1);
  localparam logic [PH_W-1:0]  CLK1_END  = PH_W'(CLK1_W);
  localparam logic [PH_W-1:0]  CLK2_BEG  = PH_W'(CLK1_W + GAP_W);
  localparam logic [PH_W-1:0]  CLK2_END  = PH_W'(CLK1_W + GAP_W + CLK2_W);
  localparam logic [POC_W-1:0] POC_LIMIT = POC_W'(POC_CYC);
  localparam logic [2:0]       SUB_X3    = 3'd7;

  typedef enum logic [2:0] {
    S_POC,
    S_RUN,
    S_HALT,
    S_STEP,
    S_ACK
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic [2:0]       sub_q, sub_d;
  logic [POC_W-1:0] poc_cnt_q, poc_cnt_d;
  logic             clk1_q, clk1_d;
  logic             clk2_q, clk2_d;
  logic             poc_q, poc_d;
  logic             cs_q, cs_d;
  logic             halted_q, halted_d;
  logic             step_ack_q, step_ack_d;
  logic             sync_err_q, sync_err_d;

  logic             running;
  logic             ph_last;
  logic             sync_chk;
  logic             resync;
  logic [2:0]       sub_eff;
  logic             cyc_end;
  logic             advance;

  // Next-state, phase/subcycle counters and registered output values.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    running    = (state_q == S_POC) || (state_q == S_RUN) || (state_q == S_STEP);
    ph_last    = (ph_cnt_q == PH_LAST);

    // SYNC is only meaningful once the core is out of clear.
    sync_chk   = running && ph_last && !poc_q;
    resync     = sync_chk && sync_in && (sub_q != SUB_X3);
    sync_err_d = sync_chk && (sync_in != (sub_q == SUB_X3));

    // A resync makes the current subcycle behave as X3 for everything below.
    sub_eff    = resync ? SUB_X3 : sub_q;
    cyc_end    = ph_last && (sub_eff == SUB_X3);

    state_d    = state_q;
    poc_cnt_d  = poc_cnt_q;
    poc_d      = poc_q;
    halted_d   = halted_q;
    step_ack_d = step_ack_q;
    advance    = running;

    case (state_q)
      S_POC: begin
        if (cyc_end) begin
          if (poc_cnt_q == POC_LIMIT) begin
            poc_d = 1'b0;
            if (run_en) begin
              state_d = S_RUN;
            end else begin
              // Stop before the A1 that would otherwise start.
              state_d  = S_HALT;
              advance  = 1'b0;
              halted_d = 1'b1;
            end
          end else begin
            poc_cnt_d = poc_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cyc_end && !run_en) begin
          state_d  = S_HALT;
          advance  = 1'b0;
          halted_d = 1'b1;
        end
      end
      S_HALT: begin
        if (run_en) begin
          state_d  = S_RUN;
          advance  = 1'b1;
          halted_d = 1'b0;
        end else if (step_req) begin
          state_d  = S_STEP;
          advance  = 1'b1;
          halted_d = 1'b0;
        end
      end
      S_STEP: begin
        if (cyc_end) begin
          state_d    = S_ACK;
          advance    = 1'b0;
          halted_d   = 1'b1;
          step_ack_d = 1'b1;
        end
      end
      S_ACK: begin
        if (!step_req) begin
          state_d    = S_HALT;
          step_ack_d = 1'b0;
        end
      end
      default: begin
        state_d = S_POC;
      end
    endcase

    // Restarting clear keeps the phase going; a stopped sequencer resumes at A1.
    if (poc_req) begin
      state_d    = S_POC;
      poc_d      = 1'b1;
      poc_cnt_d  = '0;
      step_ack_d = 1'b0;
      halted_d   = 1'b0;
      advance    = 1'b1;
    end

    if (!advance) begin
      ph_cnt_d = ph_cnt_q;
      sub_d    = sub_eff;
    end else if (ph_last) begin
      ph_cnt_d = '0;
      sub_d    = sub_eff + 3'd1;
    end else begin
      ph_cnt_d = ph_cnt_q + 1'b1;
      sub_d    = sub_eff;
    end

    // Outputs follow the updated counters so they line up with subcycle.
    clk1_d = (ph_cnt_d < CLK1_END);
    clk2_d = (ph_cnt_d >= CLK2_BEG) && (ph_cnt_d < CLK2_END);
    cs_d   = (ph_cnt_d == '0) && (sub_d == 3'd0);
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_POC;
      ph_cnt_q   <= PH_LAST;
      sub_q      <= SUB_X3;
      poc_cnt_q  <= '0;
      clk1_q     <= 1'b0;
      clk2_q     <= 1'b0;
      poc_q      <= 1'b1;
      cs_q       <= 1'b0;
      halted_q   <= 1'b0;
      step_ack_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      sub_q      <= sub_d;
      poc_cnt_q  <= poc_cnt_d;
      clk1_q     <= clk1_d;
      clk2_q     <= clk2_d;
      poc_q      <= poc_d;
      cs_q       <= cs_d;
      halted_q   <= halted_d;
      step_ack_q <= step_ack_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign clk1_out    = clk1_q;
  assign clk2_out    = clk2_q;
  assign poc_out     = poc_q;
  assign subcycle    = sub_q;
  assign cycle_start = cs_q;
  assign halted      = halted_q;
  assign step_ack    = step_ack_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_i4004_clock_sequencer.sv
// Directed bench for i4004_clock_sequencer with default parameters (P = 6).
// Inputs change and outputs are sampled on the falling edge; k counts falling
// edges since reset release, so each expected value is tied to a cycle index.
module tb_i4004_clock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_en;
  logic       step_req;
  logic       poc_req;
  logic       sync_in;
  logic       clk1_out;
  logic       clk2_out;
  logic       poc_out;
  logic [2:0] subcycle;
  logic       cycle_start;
  logic       halted;
  logic       step_ack;
  logic       sync_err;

  int checks    = 0;
  int failures  = 0;
  int k         = 0;
  int sync_mode = 0;  // 0: SYNC in X3, 1: also in subcycle 3, 2: held low

  logic [5:0] c1_pat;
  logic [5:0] c2_pat;

  i4004_clock_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .step_req   (step_req),
    .poc_req    (poc_req),
    .sync_in    (sync_in),
    .clk1_out   (clk1_out),
    .clk2_out   (clk2_out),
    .poc_out    (poc_out),
    .subcycle   (subcycle),
    .cycle_start(cycle_start),
    .halted     (halted),
    .step_ack   (step_ack),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Core model: SYNC high during X3, with injectable faults.
  always @(negedge clk) begin
    sync_in = (sync_mode == 2) ? 1'b0
            : ((subcycle == 3'd7) || ((sync_mode == 1) && (subcycle == 3'd3)));
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, act, exp, k);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic go_to(input int target);
    while (k < target) tick();
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_clk1"}, 32'(clk1_out), 0);
    check({pfx, "_clk2"}, 32'(clk2_out), 0);
    check({pfx, "_poc"}, 32'(poc_out), 1);
    check({pfx, "_sub"}, 32'(subcycle), 7);
    check({pfx, "_cs"}, 32'(cycle_start), 0);
    check({pfx, "_halted"}, 32'(halted), 0);
    check({pfx, "_ack"}, 32'(step_ack), 0);
    check({pfx, "_serr"}, 32'(sync_err), 0);
  endtask

  initial begin
    int pulses;
    int acks;
    int starts;
    int ph;
    int sb;

    c1_pat   = 6'b110000;
    c2_pat   = 6'b000110;
    rst_n    = 1'b0;
    run_en   = 1'b1;
    step_req = 1'b0;
    poc_req  = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // Power-on clear: 4 cycles of 48 sysclks, release on the 5th cycle_start.
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 193; i++) begin
      tick();
      ph = (i - 1) % 6;
      sb = ((i - 1) / 6) % 8;
      check("p1_sub", 32'(subcycle), 32'(sb));
      check("p1_clk1", 32'(clk1_out), 32'(c1_pat[5-ph]));
      check("p1_clk2", 32'(clk2_out), 32'(c2_pat[5-ph]));
      check("p1_overlap", 32'(clk1_out & clk2_out), 0);
      check("p1_cs", 32'(cycle_start), (ph == 0 && sb == 0) ? 1 : 0);
      check("p1_poc", 32'(poc_out), (i < 193) ? 1 : 0);
    end

    // Drop run_en in M1: finish through X3, then halt.
    go_to(211);
    check("m1_sub", 32'(subcycle), 3);
    run_en = 1'b0;
    go_to(240);
    check("x3_sub", 32'(subcycle), 7);
    check("x3_halted", 32'(halted), 0);
    go_to(241);
    check("halt_halted", 32'(halted), 1);
    check("halt_sub", 32'(subcycle), 7);
    check("halt_clk1", 32'(clk1_out), 0);
    check("halt_clk2", 32'(clk2_out), 0);
    check("halt_cs", 32'(cycle_start), 0);
    go_to(245);
    check("halt_hold", 32'(halted), 1);
    check("halt_hold_sub", 32'(subcycle), 7);
    run_en = 1'b1;
    go_to(246);
    check("resume_clk1", 32'(clk1_out), 1);
    check("resume_sub", 32'(subcycle), 0);
    check("resume_cs", 32'(cycle_start), 1);
    check("resume_halted", 32'(halted), 0);

    // SYNC asserted in subcycle 3: one error pulse and resync to A1.
    sync_mode = 1;
    pulses = 0;
    while (k < 270) begin
      tick();
      pulses += int'(sync_err);
    end
    check("s1_pulses", 32'(pulses), 1);
    check("s1_err", 32'(sync_err), 1);
    check("s1_resync_sub", 32'(subcycle), 0);
    check("s1_resync_cs", 32'(cycle_start), 1);
    sync_mode = 0;
    go_to(271);
    check("s1_err_clear", 32'(sync_err), 0);

    // SYNC held low: one error at the end of X3, normal wrap.
    sync_mode = 2;
    pulses = 0;
    while (k < 318) begin
      tick();
      pulses += int'(sync_err);
    end
    check("s2_pulses", 32'(pulses), 1);
    check("s2_err", 32'(sync_err), 1);
    check("s2_sub", 32'(subcycle), 0);
    sync_mode = 0;
    go_to(319);
    check("s2_err_clear", 32'(sync_err), 0);

    // poc_req in subcycle 5: clear restarts without disturbing the phase.
    go_to(348);
    check("pr_sub_before", 32'(subcycle), 5);
    poc_req = 1'b1;
    tick();
    poc_req = 1'b0;
    check("pr_poc", 32'(poc_out), 1);
    check("pr_sub", 32'(subcycle), 5);
    check("pr_clk1", 32'(clk1_out), 1);
    go_to(366);
    check("pr_wrap1_sub", 32'(subcycle), 0);
    check("pr_wrap1_cs", 32'(cycle_start), 1);
    check("pr_wrap1_poc", 32'(poc_out), 1);
    go_to(557);
    check("pr_poc_last", 32'(poc_out), 1);
    go_to(558);
    check("pr_poc_fall", 32'(poc_out), 0);
    check("pr_fall_cs", 32'(cycle_start), 1);

    // Halt, then single step with handshake.
    run_en = 1'b0;
    go_to(606);
    check("st_halted", 32'(halted), 1);
    check("st_halt_sub", 32'(subcycle), 7);
    go_to(608);
    step_req = 1'b1;
    go_to(609);
    check("st_start_halted", 32'(halted), 0);
    check("st_start_sub", 32'(subcycle), 0);
    check("st_start_cs", 32'(cycle_start), 1);
    acks = 0;
    while (k < 656) begin
      tick();
      acks += int'(step_ack) + int'(halted);
    end
    check("st_run_quiet", 32'(acks), 0);
    check("st_end_sub", 32'(subcycle), 7);
    go_to(657);
    check("st_ack", 32'(step_ack), 1);
    check("st_ack_halted", 32'(halted), 1);
    check("st_ack_sub", 32'(subcycle), 7);
    check("st_ack_clk1", 32'(clk1_out), 0);
    acks = 0;
    starts = 0;
    while (k < 670) begin
      tick();
      acks += int'(step_ack);
      starts += int'(cycle_start);
    end
    check("st_ack_hold", 32'(acks), 13);
    check("st_no_restep", 32'(starts), 0);
    step_req = 1'b0;
    go_to(671);
    check("st_ack_drop", 32'(step_ack), 0);
    check("st_drop_halted", 32'(halted), 1);

    // Reset in the middle of a step.
    go_to(675);
    step_req = 1'b1;
    go_to(676);
    check("rs_step_cs", 32'(cycle_start), 1);
    acks = 0;
    while (k < 690) begin
      tick();
      acks += int'(step_ack);
    end
    rst_n = 1'b0;
    go_to(691);
    check_reset_vals("rst_mid");
    step_req = 1'b0;
    go_to(694);
    rst_n = 1'b1;
    while (k < 700) begin
      tick();
      acks += int'(step_ack);
    end
    check("rs_no_ack", 32'(acks), 0);
    check("rs_poc", 32'(poc_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
